// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS datapath.
// Load-size encodings and the datapath width.
package cpu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: picks the byte/half lane and extends it.
// Little-endian lanes; size 2'b11 behaves as a word load.
module load_formatter
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] read_data,
    input  logic [1:0]        off,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    output logic [DATA_W-1:0] load_fmt
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        ext_bit;

    always_comb begin
        byte_lane = read_data[7:0];
        case (off)
            2'd0: byte_lane = read_data[7:0];
            2'd1: byte_lane = read_data[15:8];
            2'd2: byte_lane = read_data[23:16];
            2'd3: byte_lane = read_data[31:24];
            default: byte_lane = read_data[7:0];
        endcase
    end

    // off[0] is deliberately ignored for halfwords.
    assign half_lane = off[1] ? read_data[31:16] : read_data[15:0];

    always_comb begin
        load_fmt = read_data;
        ext_bit  = 1'b0;
        case (load_size)
            LS_HALF: begin
                ext_bit  = ~load_unsigned & half_lane[15];
                load_fmt = {{16{ext_bit}}, half_lane};
            end
            LS_BYTE: begin
                ext_bit  = ~load_unsigned & byte_lane[7];
                load_fmt = {{24{ext_bit}}, byte_lane};
            end
            default: load_fmt = read_data;
        endcase
    end

endmodule

// File: rtl/writeback_select.sv
// Write-back source select with a registered trace copy.
// WriteData_reg is combinational and feeds the register file directly.
module writeback_select #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              memtoreg,
    input  logic              link,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic              valid_in,
    output logic [DATA_W-1:0] WriteData_reg,
    output logic [DATA_W-1:0] wb_data_q,
    output logic              wb_valid_q
);

    logic [DATA_W-1:0] load_fmt;
    logic [DATA_W-1:0] wb_data_d;
    logic              wb_valid_d;

    load_formatter u_fmt (
        .read_data     (read_data),
        .off           (ALU_result[1:0]),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .load_fmt      (load_fmt)
    );

    // if/else chain keeps unknowns on unselected sources out of the result.
    always_comb begin
        if (link) begin
            WriteData_reg = pc_plus4;
        end else if (memtoreg) begin
            WriteData_reg = load_fmt;
        end else begin
            WriteData_reg = ALU_result;
        end
    end

    always_comb begin
        wb_data_d  = WriteData_reg;
        wb_valid_d = valid_in;
        if (reset) begin
            wb_data_d  = '0;
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wb_data_q  <= wb_data_d;
        wb_valid_q <= wb_valid_d;
    end

endmodule

// File: tb/tb_writeback_select.sv
// Bench for writeback_select: directed literals plus a per-cycle
// comparison against a behavioural write-back model.
module tb_writeback_select;

    logic        clk;
    logic        reset;
    logic [31:0] read_data;
    logic [31:0] ALU_result;
    logic        memtoreg;
    logic        link;
    logic [31:0] pc_plus4;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        valid_in;
    logic [31:0] WriteData_reg;
    logic [31:0] wb_data_q;
    logic        wb_valid_q;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_data;
    logic        exp_valid;
    logic        mvalid = 1'b0;

    writeback_select #(.DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .read_data     (read_data),
        .ALU_result    (ALU_result),
        .memtoreg      (memtoreg),
        .link          (link),
        .pc_plus4      (pc_plus4),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .valid_in      (valid_in),
        .WriteData_reg (WriteData_reg),
        .wb_data_q     (wb_data_q),
        .wb_valid_q    (wb_valid_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model(
        input logic        lnk,
        input logic        m2r,
        input logic [31:0] rd,
        input logic [31:0] alu,
        input logic [31:0] pc,
        input logic [1:0]  ls,
        input logic        lu
    );
        int          off;
        logic [31:0] v;
        off = int'(alu[1:0]);
        if (lnk) return pc;
        if (!m2r) return alu;
        if (ls == 2'b01) begin
            v = (rd >> (16 * (off / 2))) & 32'h0000FFFF;
            if (!lu && v >= 32'h00008000) v = v + 32'hFFFF0000;
        end else if (ls == 2'b10) begin
            v = (rd >> (8 * off)) & 32'h000000FF;
            if (!lu && v >= 32'h00000080) v = v + 32'hFFFFFF00;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Model of the trace registers.
    always @(posedge clk) begin
        exp_data  <= reset ? 32'h0 :
                     model(link, memtoreg, read_data, ALU_result,
                           pc_plus4, load_size, load_unsigned);
        exp_valid <= reset ? 1'b0 : valid_in;
        mvalid    <= 1'b1;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("cyc_wb", WriteData_reg,
            model(link, memtoreg, read_data, ALU_result,
                  pc_plus4, load_size, load_unsigned));
        if (mvalid) begin
            chk("cyc_data_q", wb_data_q, exp_data);
            chk("cyc_valid_q", {31'b0, wb_valid_q}, {31'b0, exp_valid});
        end
    end

    task automatic drive(input logic lnk, input logic m2r,
                         input logic [31:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [1:0] ls,
                         input logic lu);
        @(posedge clk);
        #2;
        link          = lnk;
        memtoreg      = m2r;
        read_data     = rd;
        ALU_result    = alu;
        pc_plus4      = pc;
        load_size     = ls;
        load_unsigned = lu;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdv [3];
        rdv[0] = 32'h80FF7F01;
        rdv[1] = 32'h7F80017E;
        rdv[2] = 32'hDEADBEEF;

        reset         = 1'b1;
        valid_in      = 1'b0;
        link          = 1'b0;
        memtoreg      = 1'b0;
        read_data     = 32'h1;
        ALU_result    = 32'h2;
        pc_plus4      = 32'h0;
        load_size     = 2'b00;
        load_unsigned = 1'b0;
        #10;
        chk("alu_sel", WriteData_reg, 32'h2);

        drive(0, 1, 32'h4, 32'h8, 0, 2'b00, 0);
        chk("word_4", WriteData_reg, 32'h4);
        drive(0, 1, 32'hFF, 32'h3, 0, 2'b00, 0);
        chk("word_ff", WriteData_reg, 32'hFF);
        drive(0, 0, 32'hFFFFFFFF, 32'h5, 0, 2'b00, 0);
        chk("alu_5", WriteData_reg, 32'h5);
        drive(0, 1, 32'h80FF7F01, 32'h1, 0, 2'b10, 0);
        chk("lb_off1", WriteData_reg, 32'h0000007F);
        drive(0, 1, 32'h80FF7F01, 32'h2, 0, 2'b10, 0);
        chk("lb_off2", WriteData_reg, 32'hFFFFFFFF);
        drive(0, 1, 32'h80FF7F01, 32'h3, 0, 2'b10, 1);
        chk("lbu_off3", WriteData_reg, 32'h00000080);
        drive(0, 1, 32'h80FF7F01, 32'h2, 0, 2'b01, 0);
        chk("lh_off2", WriteData_reg, 32'hFFFF80FF);
        drive(0, 1, 32'h80FF7F01, 32'h3, 0, 2'b11, 0);
        chk("ls11_word", WriteData_reg, 32'h80FF7F01);
        drive(1, 1, 32'h80FF7F01, 32'h2, 32'h00400008, 2'b10, 0);
        chk("link", WriteData_reg, 32'h00400008);
        chk("rst_data_q", wb_data_q, 32'h0);
        chk("rst_valid_q", {31'b0, wb_valid_q}, 32'h0);

        drive(0, 0, 32'h0, 32'hA, 0, 2'b00, 0);
        reset    = 1'b0;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        chk("q_data_a", wb_data_q, 32'hA);
        chk("q_valid_a", {31'b0, wb_valid_q}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_data", wb_data_q, 32'h0);
        chk("midrst_valid", {31'b0, wb_valid_q}, 32'h0);
        chk("midrst_wb", WriteData_reg, 32'hA);

        drive(0, 0, 32'h0, 32'hA, 0, 2'b00, 0);
        reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) begin
                drive(k[0] & k[4] & r[0], 1'b1, rdv[r],
                      32'h1000 + 32'(k % 4), 32'h00400000 + 32'(k),
                      2'(k / 4), k[4]);
                valid_in = k[1] ^ k[3];
            end
        end
        drive(0, 0, 32'hFFFFFFFF, 32'h12345678, 32'h4, 2'b10, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("tail_q", wb_data_q, 32'h12345678);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
